cmd_phase_sequencer: RTL and testbench
======================================

# cmd_phase_sequencer

- Sits between the command FIFO and the issuer in `top`.
- Releases a decomposition batch of commands first, then waits for the processing units to go idle.
- Then releases the recomposition batch and waits for idle again.
- Replaces manual FIFO pointer manipulation for phase gating. Reports completion and, optionally, the total cycle count.

## Interface

Parameters:
- `CMD_W`, default 64: width of one command word (`$bits(cmd_t)` at instantiation).
- `CNT_W`, default 20: width of the per-phase command counts.
- `IDLE_CYCLES`, default 2: consecutive cycles `i_task_idle` must be high to declare a phase drained (legal range 1..15).

Ports:
- `i_clk` in 1: clock.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_start` in 1: start pulse; latches the counts.
- `i_decomp_cnt` in CNT_W: number of decomposition commands.
- `i_recomp_cnt` in CNT_W: number of recomposition commands.
- `i_fifo_data` in CMD_W: head of the show-ahead command FIFO.
- `i_fifo_empty` in 1: FIFO empty.
- `o_fifo_read` out 1: pop FIFO head this cycle.
- `o_cmd` out CMD_W: command to issuer.
- `o_cmd_valid` out 1: `o_cmd` valid.
- `i_cmd_ready` in 1: issuer accepts `o_cmd` (issuer read strobe).
- `i_task_idle` in 1: all units idle, no work in flight (`finished_task`).
- `o_phase` out 2: 0 idle, 1 decomp, 2 recomp, 3 done.
- `o_done` out 1: both phases complete.
- `o_cycle_count` out 32: cycles from start to done.

## Operation

- FSM states: IDLE, DECOMP, DRAIN_D, RECOMP, DRAIN_R, DONE.
- IDLE:
  - `i_start` latches both counts into the remaining counter and the recomp shadow register.
  - Next state is DECOMP, or DRAIN_D if the decomp count is 0.
- DECOMP / RECOMP:
  - `o_cmd = i_fifo_data`.
  - `o_cmd_valid = !i_fifo_empty && remaining != 0`, combinational.
  - `o_fifo_read = o_cmd_valid && i_cmd_ready`.
  - Each pop decrements remaining.
  - Pop of the last command (remaining 1→0) moves to DRAIN_D or DRAIN_R respectively on the next edge.
  - An empty FIFO with remaining > 0 stalls with no pop and no error.
- DRAIN_x:
  - `o_cmd_valid` is 0.
  - The idle counter clears on entry and increments while `i_task_idle` is high. It clears whenever `i_task_idle` is low.
  - `i_task_idle` in the first DRAIN cycle is ignored, so completion flags still high from before the last issue are not counted.
  - When the counter reaches `IDLE_CYCLES`:
    - DRAIN_D loads remaining from the shadow register and moves to RECOMP, or to DRAIN_R if the recomp count is 0.
    - DRAIN_R moves to DONE.
- DONE:
  - `o_done` is 1 and the state holds.
  - `i_start` in DONE behaves as in IDLE (restart with new counts).
- `i_start` in any other state is ignored.
- FIFO contents beyond `decomp + recomp` are never popped.
- The remaining counter is CNT_W bits unsigned. It never underflows, because a pop is impossible at 0.

## Timing

- Reset values:
  - State IDLE.
  - `o_phase` 0, `o_done` 0, `o_cmd_valid` 0, `o_fifo_read` 0.
  - `o_cycle_count` 0; `o_cmd` follows `i_fifo_data`.
  - All counters 0.
- Asserting `i_rstn` low mid-phase aborts immediately (asynchronous). No pop occurs while reset is asserted.
- `i_start` sampled at edge n: DECOMP from cycle n+1, and the first pop can occur in cycle n+1.
- Throughput in an issue phase is one command per cycle while the FIFO is non-empty and `i_cmd_ready` is high.
- Minimum drain latency: 1 + `IDLE_CYCLES` cycles from DRAIN entry to the next state.
- `o_phase` and `o_done` are registered and reflect the current state.
- `i_start` and the last pop cannot coincide; `i_start` only acts in IDLE or DONE.

## Configuration

- `PHASE_SEQ_CYCLE_COUNT_EN` defined:
  - `o_cycle_count` is a 32-bit counter.
  - It clears on an accepted `i_start` and increments every cycle in DECOMP through DRAIN_R.
  - It freezes in DONE and saturates at 0xFFFFFFFF.
- Not defined: `o_cycle_count` is tied to 0 and no counter flops are synthesized.

## Test plan

- decomp=3, recomp=2, FIFO preloaded with 6 words, `i_cmd_ready`=1, `i_task_idle` rises 4 cycles after the last decomp pop:
  - Expect exactly 3 pops, then 0 pops until idle has been seen for 2 cycles, then 2 pops, then `o_done`.
  - The 6th word remains in the FIFO.
- decomp=4, `i_cmd_ready` toggling 1,0,1,0…:
  - Expect pops only in ready cycles, with 4 pops total.
  - `o_cmd` matches the FIFO order.
- decomp=0, recomp=2:
  - Expect IDLE→DRAIN_D, with no pop during the drain.
  - Then RECOMP issues 2 pops.
- `i_task_idle` held high throughout, decomp=1:
  - Expect DRAIN_D to last exactly 1 + 2 = 3 cycles.
  - An idle pulse of 1 cycle followed by low restarts the count.
- Reset asserted in RECOMP after 1 of 5 pops:
  - Expect `o_fifo_read`, `o_cmd_valid` and `o_phase` to be 0 asynchronously.
  - A new `i_start` restarts from DECOMP.
- With `PHASE_SEQ_CYCLE_COUNT_EN` defined, decomp=2, recomp=2, always ready, idle high from the first drain cycle:
  - `o_cycle_count` = 2+3+2+3 = 10 in DONE, stable for 5 cycles.
- Without the macro, `o_cycle_count` stays 0.

Source files
------------

// File: rtl/cmd_phase_sequencer.sv
// cmd_phase_sequencer: gates a show-ahead command FIFO into two issue phases
// (decomposition, then recomposition). After each phase it waits until the
// processing units have been idle for IDLE_CYCLES consecutive cycles.
// Optional feature macro: PHASE_SEQ_CYCLE_COUNT_EN enables the start-to-done
// cycle counter on o_cycle_count; without it o_cycle_count is tied to 0.
module cmd_phase_sequencer #(
  parameter int unsigned CMD_W       = 64,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned IDLE_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_decomp_cnt,
  input  logic [CNT_W-1:0] i_recomp_cnt,
  input  logic [CMD_W-1:0] i_fifo_data,
  input  logic             i_fifo_empty,
  output logic             o_fifo_read,
  output logic [CMD_W-1:0] o_cmd,
  output logic             o_cmd_valid,
  input  logic             i_cmd_ready,
  input  logic             i_task_idle,
  output logic [1:0]       o_phase,
  output logic             o_done,
  output logic [31:0]      o_cycle_count
);

  // Idle counter only needs to reach IDLE_CYCLES, which is at most 15.
  localparam int unsigned IDLE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECOMP  = 3'd1,
    ST_DRAIN_D = 3'd2,
    ST_RECOMP  = 3'd3,
    ST_DRAIN_R = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [CNT_W-1:0]    shadow_q, shadow_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [IDLE_W-1:0]   idle_inc;
  logic                drain_first_q, drain_first_d;
  logic [1:0]          phase_q, phase_d;
  logic                done_q, done_d;
  logic                cmd_valid;
  logic                fifo_read;

  // State and datapath registers; reset aborts any phase immediately.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      shadow_q      <= '0;
      idle_cnt_q    <= '0;
      drain_first_q <= 1'b0;
      phase_q       <= 2'd0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      shadow_q      <= shadow_d;
      idle_cnt_q    <= idle_cnt_d;
      drain_first_q <= drain_first_d;
      phase_q       <= phase_d;
      done_q        <= done_d;
    end
  end

  // Next-state, counter updates and the combinational issue handshake.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    shadow_d      = shadow_q;
    idle_cnt_d    = idle_cnt_q;
    drain_first_d = drain_first_q;
    cmd_valid     = 1'b0;
    fifo_read     = 1'b0;
    idle_inc      = idle_cnt_q + IDLE_W'(1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          remaining_d = i_decomp_cnt;
          shadow_d    = i_recomp_cnt;
          if (i_decomp_cnt == '0) begin
            state_d       = ST_DRAIN_D;
            idle_cnt_d    = '0;
            drain_first_d = 1'b1;
          end else begin
            state_d = ST_DECOMP;
          end
        end
      end

      ST_DECOMP, ST_RECOMP: begin
        cmd_valid = !i_fifo_empty && (remaining_q != '0);
        fifo_read = cmd_valid && i_cmd_ready;
        if (fifo_read) begin
          remaining_d = remaining_q - CNT_W'(1);
        end
        // Leave once the last command of the batch has been popped.
        if ((remaining_q == '0) || (fifo_read && (remaining_q == CNT_W'(1)))) begin
          state_d       = (state_q == ST_DECOMP) ? ST_DRAIN_D : ST_DRAIN_R;
          idle_cnt_d    = '0;
          drain_first_d = 1'b1;
        end
      end

      ST_DRAIN_D, ST_DRAIN_R: begin
        drain_first_d = 1'b0;
        if (drain_first_q || !i_task_idle) begin
          // First drain cycle may still see stale idle from before the last issue.
          idle_cnt_d = '0;
        end else if (idle_inc == IDLE_W'(IDLE_CYCLES)) begin
          idle_cnt_d = '0;
          if (state_q == ST_DRAIN_D) begin
            remaining_d = shadow_q;
            if (shadow_q == '0) begin
              state_d       = ST_DRAIN_R;
              drain_first_d = 1'b1;
            end else begin
              state_d = ST_RECOMP;
            end
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          idle_cnt_d = idle_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Phase/done are registered copies of the state being entered.
  always_comb begin
    phase_d = 2'd0;
    done_d  = 1'b0;
    case (state_d)
      ST_DECOMP, ST_DRAIN_D: phase_d = 2'd1;
      ST_RECOMP, ST_DRAIN_R: phase_d = 2'd2;
      ST_DONE: begin
        phase_d = 2'd3;
        done_d  = 1'b1;
      end
      default: phase_d = 2'd0;
    endcase
  end

  assign o_cmd       = i_fifo_data;
  assign o_cmd_valid = cmd_valid;
  assign o_fifo_read = fifo_read;
  assign o_phase     = phase_q;
  assign o_done      = done_q;

`ifdef PHASE_SEQ_CYCLE_COUNT_EN
  localparam int unsigned CC_W = 32;

  logic [CC_W-1:0] cycle_cnt_q;
  logic            start_ok;
  logic            counting;

  assign start_ok = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign counting = (state_q == ST_DECOMP) || (state_q == ST_DRAIN_D) ||
                    (state_q == ST_RECOMP) || (state_q == ST_DRAIN_R);

  // Start-to-done cycle counter: clears on start, freezes in DONE, saturates.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cycle_cnt_q <= '0;
    end else if (start_ok) begin
      cycle_cnt_q <= '0;
    end else if (counting && (cycle_cnt_q != {CC_W{1'b1}})) begin
      cycle_cnt_q <= cycle_cnt_q + CC_W'(1);
    end
  end

  assign o_cycle_count = cycle_cnt_q;
`else
  assign o_cycle_count = 32'd0;
`endif

  // A pop always has data behind it and an accepting issuer.
  a_pop_has_data: assert property (@(posedge i_clk) disable iff (!i_rstn)
    o_fifo_read |-> (!i_fifo_empty && i_cmd_ready));

  // Nothing is offered to the issuer while a phase drains.
  a_drain_quiet: assert property (@(posedge i_clk) disable iff (!i_rstn)
    ((state_q == ST_DRAIN_D) || (state_q == ST_DRAIN_R)) |-> !o_cmd_valid);

  // DONE holds until a new start arrives.
  a_done_holds: assert property (@(posedge i_clk) disable iff (!i_rstn)
    ((state_q == ST_DONE) && !i_start) |=> (state_q == ST_DONE));

endmodule

// File: tb/tb_cmd_phase_sequencer.sv
// Bench for cmd_phase_sequencer: per-cycle stimulus tables, a timeline model
// of the phase sequence, and a queue-based FIFO/issuer.
module tb_cmd_phase_sequencer;

  localparam int unsigned CMD_W    = 64;
  localparam int unsigned CNT_W    = 20;
  localparam int          IDLE_CYC = 2;
  localparam int          MAXC     = 256;
`ifdef PHASE_SEQ_CYCLE_COUNT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic             i_clk;
  logic             i_rstn;
  logic             i_start;
  logic [CNT_W-1:0] i_decomp_cnt;
  logic [CNT_W-1:0] i_recomp_cnt;
  logic [CMD_W-1:0] i_fifo_data;
  logic             i_fifo_empty;
  logic             o_fifo_read;
  logic [CMD_W-1:0] o_cmd;
  logic             o_cmd_valid;
  logic             i_cmd_ready;
  logic             i_task_idle;
  logic [1:0]       o_phase;
  logic             o_done;
  logic [31:0]      o_cycle_count;

  cmd_phase_sequencer #(.CMD_W(CMD_W), .CNT_W(CNT_W), .IDLE_CYCLES(IDLE_CYC)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start),
    .i_decomp_cnt(i_decomp_cnt), .i_recomp_cnt(i_recomp_cnt),
    .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty), .o_fifo_read(o_fifo_read),
    .o_cmd(o_cmd), .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .i_task_idle(i_task_idle), .o_phase(o_phase), .o_done(o_done),
    .o_cycle_count(o_cycle_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks;
  int errors;

  // Per-cycle stimulus tables (cycle 0 is the start cycle).
  logic rdy_a [MAXC];
  logic avl_a [MAXC];
  logic idl_a [MAXC];
  // Observation word: {phase[1:0], done, cmd_valid, fifo_read}.
  logic [4:0]  exp_sig [MAXC];
  logic [4:0]  obs_sig [MAXC];
  logic [31:0] obs_cc  [MAXC];
  logic [CMD_W-1:0] fifo_q[$];
  logic [CMD_W-1:0] load_q[$];
  logic [CMD_W-1:0] pop_q[$];
  int exp_done;
  int obs_done;
  int run_len;
  logic [1:0] prev_phase;

  // One clock cycle: drive, sample just after the inputs settle, then let the FIFO pop.
  task automatic tick(input logic st, input logic rdy, input logic avl, input logic idl,
                      output logic [4:0] sig, output logic [31:0] cc);
    i_start      = st;
    i_cmd_ready  = rdy;
    i_task_idle  = idl;
    i_fifo_empty = !avl || (fifo_q.size() == 0);
    i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    sig = {o_phase, o_done, o_cmd_valid, o_fifo_read};
    cc  = o_cycle_count;
    if (o_fifo_read) pop_q.push_back(o_cmd);
    @(posedge i_clk);
    if (sig[0] && (fifo_q.size() != 0)) void'(fifo_q.pop_front());
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Timeline model: issue phases consume the ready&&available cycles until the
  // batch is gone; a drain ends at the first window of IDLE_CYC consecutive
  // idle cycles lying entirely after the drain's first cycle.
  task automatic build_model(input int dc, input int rc);
    int t, n, e;
    bit ok;
    for (int c = 0; c < MAXC; c++) exp_sig[c] = {2'd3, 1'b1, 2'b00};
    exp_sig[0] = {prev_phase, (prev_phase == 2'd3), 2'b00};
    t = 1;
    for (int ph = 1; ph <= 2; ph++) begin
      n = (ph == 1) ? dc : rc;
      while (n > 0 && t < MAXC) begin
        exp_sig[t] = {2'(ph), 1'b0, avl_a[t], rdy_a[t] && avl_a[t]};
        if (rdy_a[t] && avl_a[t]) n--;
        t++;
      end
      e  = t + IDLE_CYC;
      ok = 1'b0;
      while (!ok && e < MAXC) begin
        ok = 1'b1;
        for (int k = 0; k < IDLE_CYC; k++) if (!idl_a[e-k]) ok = 1'b0;
        if (!ok) e++;
      end
      for (int c = t; c <= e && c < MAXC; c++) exp_sig[c] = {2'(ph), 3'b000};
      t = e + 1;
    end
    exp_done = t;
  endtask

  // Loads the FIFO, starts the sequencer and records every cycle's outputs.
  task automatic run_scenario(input int dc, input int rc, input int extra);
    logic [4:0]  s;
    logic [31:0] cc;
    logic [CMD_W-1:0] w;
    fifo_q.delete(); load_q.delete(); pop_q.delete();
    for (int i = 0; i < dc + rc + extra; i++) begin
      w = {$urandom, $urandom};
      fifo_q.push_back(w);
      load_q.push_back(w);
    end
    i_decomp_cnt = CNT_W'(dc);
    i_recomp_cnt = CNT_W'(rc);
    build_model(dc, rc);
    run_len  = (exp_done + 6 < MAXC) ? exp_done + 6 : MAXC;
    obs_done = -1;
    for (int c = 0; c < run_len; c++) begin
      tick(c == 0, rdy_a[c], avl_a[c], idl_a[c], s, cc);
      // Counts only matter at start; scramble them afterwards.
      i_decomp_cnt = CNT_W'($urandom);
      i_recomp_cnt = CNT_W'($urandom);
      obs_sig[c] = s;
      obs_cc[c]  = cc;
      if (obs_done < 0 && c > 0 && s[4:3] == 2'd3) obs_done = c;
    end
    prev_phase = obs_sig[run_len-1][4:3];
  endtask

  task automatic fill_stim(input bit rdy, input bit avl, input bit idl);
    for (int c = 0; c < MAXC; c++) begin
      rdy_a[c] = rdy;
      avl_a[c] = avl;
      idl_a[c] = idl;
    end
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_start = 1'b0; i_cmd_ready = 1'b1; i_task_idle = 1'b1;
    i_decomp_cnt = '0; i_recomp_cnt = '0; i_fifo_empty = 1'b0;
    i_fifo_data = 64'h0123_4567_89ab_cdef;
    #1;
    checks++;
    if ({o_phase, o_done, o_cmd_valid, o_fifo_read} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=00000", {o_phase, o_done, o_cmd_valid, o_fifo_read});
    end
    checks++;
    if (o_cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle_count got=%0d exp=0", o_cycle_count); end
    checks++;
    if (o_cmd !== 64'h0123_4567_89ab_cdef) begin errors++; $display("FAIL reset_cmd_passthru got=%h exp=%h", o_cmd, 64'h0123_4567_89ab_cdef); end
    @(negedge i_clk); @(negedge i_clk);
    i_rstn = 1'b1;
    prev_phase = 2'd0;
  endtask

  task automatic test_basic();
    fill_stim(1, 1, 0);
    for (int c = 7; c < MAXC; c++) idl_a[c] = 1'b1;
    run_scenario(3, 2, 1);
    for (int c = 0; c < run_len; c++) begin
      checks++;
      if (obs_sig[c] !== exp_sig[c]) begin errors++; $display("FAIL basic_sig cyc=%0d got=%b exp=%b", c, obs_sig[c], exp_sig[c]); end
    end
    checks++;
    if (obs_done != 14) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=14", obs_done); end
    checks++;
    if (pop_q.size() != 5) begin errors++; $display("FAIL basic_pop_count got=%0d exp=5", pop_q.size()); end
    for (int i = 0; i < 5 && i < pop_q.size(); i++) begin
      checks++;
      if (pop_q[i] !== load_q[i]) begin errors++; $display("FAIL basic_cmd idx=%0d got=%h exp=%h", i, pop_q[i], load_q[i]); end
    end
    checks++;
    if (fifo_q.size() != 1 || fifo_q[0] !== load_q[5]) begin errors++; $display("FAIL basic_leftover got=%0d words exp=1", fifo_q.size()); end
  endtask

  task automatic test_ready_toggle();
    int bad;
    fill_stim(1, 1, 1);
    for (int c = 0; c < MAXC; c++) rdy_a[c] = (c % 2 == 1);
    run_scenario(4, 0, 2);
    bad = 0;
    for (int c = 0; c < run_len; c++) begin
      checks++;
      if (obs_sig[c] !== exp_sig[c]) begin errors++; $display("FAIL toggle_sig cyc=%0d got=%b exp=%b", c, obs_sig[c], exp_sig[c]); end
      if (obs_sig[c][0] && !rdy_a[c]) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL toggle_pop_without_ready got=%0d exp=0", bad); end
    checks++;
    if (pop_q.size() != 4) begin errors++; $display("FAIL toggle_pop_count got=%0d exp=4", pop_q.size()); end
    for (int i = 0; i < 4 && i < pop_q.size(); i++) begin
      checks++;
      if (pop_q[i] !== load_q[i]) begin errors++; $display("FAIL toggle_cmd idx=%0d got=%h exp=%h", i, pop_q[i], load_q[i]); end
    end
  endtask

  task automatic test_zero_decomp();
    fill_stim(1, 1, 1);
    run_scenario(0, 2, 1);
    for (int c = 0; c < run_len; c++) begin
      checks++;
      if (obs_sig[c] !== exp_sig[c]) begin errors++; $display("FAIL zero_sig cyc=%0d got=%b exp=%b", c, obs_sig[c], exp_sig[c]); end
    end
    checks++;
    if (obs_sig[1] !== {2'd1, 3'b000}) begin errors++; $display("FAIL zero_drain_entry got=%b exp=01000", obs_sig[1]); end
    checks++;
    if (obs_done != 9) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=9", obs_done); end
    checks++;
    if (pop_q.size() != 2 || pop_q[0] !== load_q[0] || pop_q[1] !== load_q[1]) begin
      errors++; $display("FAIL zero_pops got=%0d pops exp=2 in order", pop_q.size());
    end
  endtask

  task automatic test_idle_drain();
    int drain_len;
    fill_stim(1, 1, 1);
    run_scenario(1, 0, 1);
    drain_len = 0;
    for (int c = 1; c < run_len; c++) if (obs_sig[c][4:3] == 2'd1 && !obs_sig[c][1]) drain_len++;
    checks++;
    if (drain_len != 1 + IDLE_CYC) begin errors++; $display("FAIL idle_held_drain_len got=%0d exp=%0d", drain_len, 1 + IDLE_CYC); end
    for (int c = 0; c < run_len; c++) begin
      checks++;
      if (obs_sig[c] !== exp_sig[c]) begin errors++; $display("FAIL idle_held_sig cyc=%0d got=%b exp=%b", c, obs_sig[c], exp_sig[c]); end
    end
    // A lone idle pulse followed by low must restart the window.
    fill_stim(1, 1, 1);
    idl_a[4] = 1'b0;
    run_scenario(1, 0, 1);
    for (int c = 0; c < run_len; c++) begin
      checks++;
      if (obs_sig[c] !== exp_sig[c]) begin errors++; $display("FAIL idle_pulse_sig cyc=%0d got=%b exp=%b", c, obs_sig[c], exp_sig[c]); end
    end
    checks++;
    if (obs_done != 10) begin errors++; $display("FAIL idle_pulse_done_cycle got=%0d exp=10", obs_done); end
  endtask

  task automatic test_reset_mid();
    logic [4:0]  s;
    logic [31:0] cc;
    int pops_r, sz;
    fifo_q.delete(); pop_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back({$urandom, $urandom});
    i_decomp_cnt = CNT_W'(1);
    i_recomp_cnt = CNT_W'(5);
    pops_r = 0;
    for (int c = 0; c < 20 && pops_r < 1; c++) begin
      tick(c == 0, 1'b1, 1'b1, 1'b1, s, cc);
      if (s[4:3] == 2'd2 && s[0]) pops_r++;
    end
    checks++;
    if (pops_r != 1) begin errors++; $display("FAIL rstmid_reach_recomp got=%0d pops exp=1", pops_r); end
    i_cmd_ready = 1'b1; i_fifo_empty = 1'b0; i_fifo_data = fifo_q[0];
    #2;
    checks++;
    if ({o_phase, o_cmd_valid, o_fifo_read} !== 4'b1011) begin
      errors++; $display("FAIL rstmid_pre got=%b exp=1011", {o_phase, o_cmd_valid, o_fifo_read});
    end
    i_rstn = 1'b0;
    #1;
    checks++;
    if ({o_phase, o_done, o_cmd_valid, o_fifo_read} !== 5'b0) begin
      errors++; $display("FAIL rstmid_async got=%b exp=00000", {o_phase, o_done, o_cmd_valid, o_fifo_read});
    end
    @(negedge i_clk);
    sz = fifo_q.size();
    tick(1'b0, 1'b1, 1'b1, 1'b1, s, cc);
    tick(1'b1, 1'b1, 1'b1, 1'b1, s, cc);
    checks++;
    if (fifo_q.size() != sz || s !== 5'b0) begin errors++; $display("FAIL rstmid_no_pop_in_reset got=%0d words sig=%b exp=%0d words", fifo_q.size(), s, sz); end
    i_rstn = 1'b1;
    prev_phase = 2'd0;
    fill_stim(1, 1, 1);
    run_scenario(2, 1, 1);
    for (int c = 0; c < run_len; c++) begin
      checks++;
      if (obs_sig[c] !== exp_sig[c]) begin errors++; $display("FAIL rstmid_restart_sig cyc=%0d got=%b exp=%b", c, obs_sig[c], exp_sig[c]); end
    end
  endtask

  task automatic test_cycle_count();
    logic [31:0] want;
    fill_stim(1, 1, 1);
    run_scenario(2, 2, 0);
    checks++;
    if (obs_done != 11) begin errors++; $display("FAIL cc_done_cycle got=%0d exp=11", obs_done); end
    want = CC_EN ? 32'd10 : 32'd0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs_cc[11+k] !== want) begin errors++; $display("FAIL cc_value cyc=%0d got=%0d exp=%0d", 11 + k, obs_cc[11+k], want); end
    end
  endtask

  task automatic test_random();
    int dc, rc;
    logic [31:0] want;
    for (int it = 0; it < 40; it++) begin
      dc = $urandom_range(0, 6);
      rc = $urandom_range(0, 6);
      for (int c = 0; c < MAXC; c++) begin
        rdy_a[c] = (c >= 120) || ($urandom_range(0, 3) != 0);
        avl_a[c] = (c >= 120) || ($urandom_range(0, 4) != 0);
        idl_a[c] = (c >= 120) || ($urandom_range(0, 3) != 0);
      end
      run_scenario(dc, rc, $urandom_range(0, 3));
      for (int c = 0; c < run_len; c++) begin
        checks++;
        if (obs_sig[c] !== exp_sig[c]) begin errors++; $display("FAIL rand_sig it=%0d cyc=%0d got=%b exp=%b", it, c, obs_sig[c], exp_sig[c]); end
      end
      for (int c = 1; c < run_len; c++) begin
        want = !CC_EN ? 32'd0 : (c <= exp_done) ? 32'(c - 1) : 32'(exp_done - 1);
        checks++;
        if (obs_cc[c] !== want) begin errors++; $display("FAIL rand_cc it=%0d cyc=%0d got=%0d exp=%0d", it, c, obs_cc[c], want); end
      end
      checks++;
      if (pop_q.size() != dc + rc) begin errors++; $display("FAIL rand_pop_count it=%0d got=%0d exp=%0d", it, pop_q.size(), dc + rc); end
      for (int i = 0; i < pop_q.size() && i < load_q.size(); i++) begin
        checks++;
        if (pop_q[i] !== load_q[i]) begin errors++; $display("FAIL rand_cmd it=%0d idx=%0d got=%h exp=%h", it, i, pop_q[i], load_q[i]); end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_ready_toggle();
    test_zero_decomp();
    test_idle_drain();
    test_reset_mid();
    test_cycle_count();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
